// File: rtl/trng_pkg.sv
// Shared definitions for the TinyQV TRNG FIFO peripheral: register map,
// CTRL/STATUS bit positions and the stored control-register layout.
package trng_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_DATA   = 4'h2;
  localparam logic [3:0] ADDR_RCT    = 4'h3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_VN      = 1;
  localparam int CTRL_SRC     = 2;
  localparam int CTRL_FLUSH   = 3;
  localparam int CTRL_DIV_LSB = 4;

  localparam int STATUS_NONEMPTY = 0;
  localparam int STATUS_FULL     = 1;
  localparam int STATUS_HEALTH   = 2;
  localparam int STATUS_OVF      = 3;
  localparam int STATUS_CNT_LSB  = 4;

  // Layout matches the CTRL read-back; flush is never stored as 1.
  typedef struct packed {
    logic [3:0] div;
    logic       flush;
    logic       src;
    logic       vn_en;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/trng_ro_bank.sv
// Bank of free-running inverter rings. Each ring's last tap is sampled every
// clock and the sampled taps are XOR-folded into a single raw bit. The first
// stage is a NAND with the enable so an idle bank sits in a quiet, static state.
module trng_ro_bank
  import trng_pkg::*;
#(
  parameter int N_RO    = 20,
  parameter int SIZE_RO = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic raw_bit
);

  logic [N_RO-1:0] ring_out;
  logic [N_RO-1:0] taps_q;

  for (genvar r = 0; r < N_RO; r++) begin : g_ring
    (* keep = "true", dont_touch = "true" *) logic [SIZE_RO-1:0] ring;
    assign ring[0] = ~(ring[SIZE_RO-1] & enable);
    for (genvar s = 1; s < SIZE_RO; s++) begin : g_stage
      assign ring[s] = ~ring[s-1];
    end
    assign ring_out[r] = ring[SIZE_RO-1];
  end

  // Capture the asynchronous ring taps into the clock domain.
  always_ff @(posedge clk) begin
    if (!rst_n) taps_q <= '0;
    else        taps_q <= ring_out;
  end

  assign raw_bit = ^taps_q;

endmodule

// File: rtl/tqvp_trng_fifo.sv
// TinyQV TRNG peripheral: entropy source select, clock divider, optional von
// Neumann debiaser, repetition-count health test, LSB-first byte assembly and
// a small byte FIFO read through the peripheral register bus.
module tqvp_trng_fifo
  import trng_pkg::*;
#(
  parameter int         N_RO           = 20,
  parameter int         SIZE_RO        = 7,
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [7:0] RCT_CUTOFF_RST = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  ctrl_t      ctrl_q;
  logic [7:0] rct_cutoff;
  logic       health_fail, overflow;
  logic [3:0] div_cnt;
  logic       ext_q, ro_bit, ro_en;
  logic       vn_have, vn_first;
  logic       rct_have, rct_prev;
  logic [7:0] run_cnt;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic       wr_ctrl, wr_status, wr_data, wr_rct, flush;
  logic       tick, raw_bit, accept, acc_bit, rct_evt;
  logic [7:0] run_next, byte_next;
  logic       push_req, do_push, do_pop, ovf_evt, nonempty;
  logic [7:0] status;
  logic       unused_ui;

  assign unused_ui = ^ui_in[7:1];
  assign ro_en     = ctrl_q.en & ~ctrl_q.src;

  trng_ro_bank #(.N_RO(N_RO), .SIZE_RO(SIZE_RO)) u_ro_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (ro_en),
    .raw_bit (ro_bit)
  );

  // Datapath decisions for this cycle: bus decode, tick, debias, health, FIFO.
  always_comb begin
    wr_ctrl   = data_write && (address == ADDR_CTRL);
    wr_status = data_write && (address == ADDR_STATUS);
    wr_data   = data_write && (address == ADDR_DATA);
    wr_rct    = data_write && (address == ADDR_RCT);
    flush     = wr_ctrl && data_in[CTRL_FLUSH];

    tick    = ctrl_q.en && (div_cnt == 4'd0);
    raw_bit = ctrl_q.src ? ext_q : ro_bit;

    if (ctrl_q.vn_en) begin
      accept  = tick && vn_have && (vn_first != raw_bit);
      acc_bit = vn_first;
    end else begin
      accept  = tick;
      acc_bit = raw_bit;
    end

    if (rct_have && (raw_bit == rct_prev))
      run_next = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
    else
      run_next = 8'd1;
    rct_evt = tick && (rct_cutoff != 8'd0) && (run_next >= rct_cutoff);

    byte_next = {acc_bit, sr[7:1]};
    push_req  = accept && (bit_cnt == 3'd7) && !health_fail && !flush;
    nonempty  = (count != '0);
    do_pop    = wr_data && nonempty && !flush;
    do_push   = push_req && ((count != CNT_FULL) || do_pop);
    ovf_evt   = push_req && (count == CNT_FULL) && !do_pop;
  end

  // Control registers and sticky status flags; a new set event beats a W1C.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      rct_cutoff  <= RCT_CUTOFF_RST;
      health_fail <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q.en    <= data_in[CTRL_EN];
        ctrl_q.vn_en <= data_in[CTRL_VN];
        ctrl_q.src   <= data_in[CTRL_SRC];
        ctrl_q.div   <= data_in[CTRL_DIV_LSB +: 4];
        ctrl_q.flush <= 1'b0;
      end
      if (wr_rct) rct_cutoff <= data_in;
      health_fail <= (health_fail & ~(wr_status & data_in[STATUS_HEALTH])) | rct_evt;
      overflow    <= (overflow & ~(wr_status & data_in[STATUS_OVF])) | ovf_evt;
    end
  end

  // Sampling front end: external bit register, divider, VN pair latch, run counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_q    <= 1'b0;
      div_cnt  <= 4'd0;
      vn_have  <= 1'b0;
      vn_first <= 1'b0;
      rct_have <= 1'b0;
      rct_prev <= 1'b0;
      run_cnt  <= 8'd0;
    end else begin
      ext_q <= ui_in[0];
      if (!ctrl_q.en) begin
        div_cnt  <= 4'd0;
        vn_have  <= 1'b0;
        vn_first <= 1'b0;
        rct_have <= 1'b0;
        rct_prev <= 1'b0;
        run_cnt  <= 8'd0;
      end else if (tick) begin
        div_cnt  <= ctrl_q.div;
        vn_have  <= ctrl_q.vn_en ? ~vn_have : 1'b0;
        vn_first <= raw_bit;
        rct_have <= 1'b1;
        rct_prev <= raw_bit;
        run_cnt  <= run_next;
      end else begin
        div_cnt <= div_cnt - 4'd1;
      end
    end
  end

  // Byte assembler: accepted bits enter at the top and shift toward bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n || !ctrl_q.en || flush) begin
      sr      <= 8'd0;
      bit_cnt <= 3'd0;
    end else if (accept) begin
      sr      <= byte_next;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Byte FIFO; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= byte_next;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  // Register read mux and pin outputs.
  always_comb begin
    status = 8'd0;
    status[STATUS_NONEMPTY] = nonempty;
    status[STATUS_FULL]     = (count == CNT_FULL);
    status[STATUS_HEALTH]   = health_fail;
    status[STATUS_OVF]      = overflow;
    status[STATUS_CNT_LSB +: 4] = 4'(count);

    case (address)
      ADDR_CTRL:   data_out = ctrl_q;
      ADDR_STATUS: data_out = status;
      ADDR_DATA:   data_out = nonempty ? mem[rd_ptr] : 8'h00;
      ADDR_RCT:    data_out = rct_cutoff;
      default:     data_out = 8'h00;
    endcase

    uo_out = {6'd0, health_fail, nonempty};
  end

endmodule

// File: tb/tb_tqvp_trng_fifo.sv
// Directed bench for the TRNG FIFO peripheral using the external entropy bit.
module tb_tqvp_trng_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_cmp = 0;
  int n_err = 0;

  tqvp_trng_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; data_in = d; data_write = 1'b1;
    @(posedge clk); #1;
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    address = a; data_write = 1'b0;
    @(negedge clk);
    d = data_out;
  endtask

  // Enable with c_on while presenting bits[0]; edge i then consumes bits[i-1].
  // The final consuming edge also writes c_off; pop_edge adds a DATA write.
  task automatic feed(input logic [7:0] c_on, input logic [63:0] bits, input int n,
                      input int pop_edge, input logic [7:0] c_off);
    ui_in = {7'd0, bits[0]};
    address = 4'h0; data_in = c_on; data_write = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= n; i++) begin
      data_write = 1'b0;
      if (i < n) ui_in[0] = bits[i];
      if (i == pop_edge) begin address = 4'h2; data_write = 1'b1; end
      if (i == n) begin address = 4'h0; data_in = c_off; data_write = 1'b1; end
      @(posedge clk); #1;
    end
    data_write = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst_n = 1'b0; ui_in = 8'd0; address = 4'd0; data_write = 1'b0; data_in = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(4'h0, v);
    if (v !== 8'h00) begin $display("FAIL reset_ctrl: got %02h exp 00", v); n_err++; end
    n_cmp++;
    rd(4'h1, v);
    if (v !== 8'h00) begin $display("FAIL reset_status: got %02h exp 00", v); n_err++; end
    n_cmp++;
    rd(4'h2, v);
    if (v !== 8'h00) begin $display("FAIL reset_data: got %02h exp 00", v); n_err++; end
    n_cmp++;
    rd(4'h3, v);
    if (v !== 8'h20) begin $display("FAIL reset_rct: got %02h exp 20", v); n_err++; end
    n_cmp++;
    if (uo_out !== 8'h00) begin $display("FAIL reset_uo: got %02h exp 00", uo_out); n_err++; end
    n_cmp++;
    wr(4'h5, 8'hFF);
    rd(4'h5, v);
    if (v !== 8'h00) begin $display("FAIL unmapped_read: got %02h exp 00", v); n_err++; end
    n_cmp++;
    rd(4'h0, v);
    if (v !== 8'h00) begin $display("FAIL unmapped_write_ctrl: got %02h exp 00", v); n_err++; end
    n_cmp++;
  endtask

  task automatic test_packing;
    logic [7:0] v;
    feed(8'h05, 64'h4D, 8, 0, 8'h00);
    rd(4'h2, v);
    if (v !== 8'h4D) begin $display("FAIL pack_data: got %02h exp 4d", v); n_err++; end
    n_cmp++;
    rd(4'h1, v);
    if (v !== 8'h11) begin $display("FAIL pack_status: got %02h exp 11", v); n_err++; end
    n_cmp++;
    if (uo_out !== 8'h01) begin $display("FAIL pack_uo: got %02h exp 01", uo_out); n_err++; end
    n_cmp++;
    wr(4'h2, 8'h00);
  endtask

  task automatic test_debias;
    logic [7:0] v;
    // pairs 01,00,10,11 x4 -> emitted bits 0,1 x4 -> 0xAA
    feed(8'h07, 64'hD2D2D2D2, 32, 0, 8'h00);
    rd(4'h1, v);
    if (v !== 8'h11) begin $display("FAIL vn_status: got %02h exp 11", v); n_err++; end
    n_cmp++;
    rd(4'h2, v);
    if (v !== 8'hAA) begin $display("FAIL vn_data: got %02h exp aa", v); n_err++; end
    n_cmp++;
    wr(4'h2, 8'h00);
  endtask

  task automatic test_overflow;
    logic [7:0] v;
    feed(8'h05, 64'h0504030201, 40, 0, 8'h00);
    rd(4'h1, v);
    if (v !== 8'h4B) begin $display("FAIL ovf_status: got %02h exp 4b", v); n_err++; end
    n_cmp++;
    for (int k = 1; k <= 4; k++) begin
      rd(4'h2, v);
      if (v !== 8'(k)) begin $display("FAIL ovf_order%0d: got %02h exp %02h", k, v, 8'(k)); n_err++; end
      n_cmp++;
      wr(4'h2, 8'h00);
    end
    rd(4'h1, v);
    if (v !== 8'h08) begin $display("FAIL ovf_drained: got %02h exp 08", v); n_err++; end
    n_cmp++;
    wr(4'h1, 8'h08);
    rd(4'h1, v);
    if (v !== 8'h00) begin $display("FAIL ovf_w1c: got %02h exp 00", v); n_err++; end
    n_cmp++;
  endtask

  task automatic test_health;
    logic [7:0] v;
    wr(4'h3, 8'h04);
    feed(8'h05, 64'hAAAAF, 20, 0, 8'h00);
    rd(4'h1, v);
    if (v !== 8'h04) begin $display("FAIL health_status: got %02h exp 04", v); n_err++; end
    n_cmp++;
    if (uo_out !== 8'h02) begin $display("FAIL health_uo: got %02h exp 02", uo_out); n_err++; end
    n_cmp++;
    wr(4'h1, 8'h04);
    rd(4'h1, v);
    if (v !== 8'h00) begin $display("FAIL health_w1c: got %02h exp 00", v); n_err++; end
    n_cmp++;
    feed(8'h05, 64'hAA, 8, 0, 8'h00);
    rd(4'h1, v);
    if (v !== 8'h11) begin $display("FAIL health_resume_status: got %02h exp 11", v); n_err++; end
    n_cmp++;
    rd(4'h2, v);
    if (v !== 8'hAA) begin $display("FAIL health_resume_data: got %02h exp aa", v); n_err++; end
    n_cmp++;
    wr(4'h3, 8'h20);
    wr(4'h2, 8'h00);
  endtask

  task automatic test_back_to_back;
    logic [7:0] v;
    wr(4'h0, 8'h08);
    // fifth byte lands on edge 40 together with a pop of the full FIFO
    feed(8'h05, 64'h0000005544332211, 41, 40, 8'h00);
    rd(4'h1, v);
    if (v !== 8'h43) begin $display("FAIL pushpop_status: got %02h exp 43", v); n_err++; end
    n_cmp++;
    rd(4'h2, v);
    if (v !== 8'h22) begin $display("FAIL pushpop_head: got %02h exp 22", v); n_err++; end
    n_cmp++;
    // flush written on the same edge that completes a byte
    feed(8'h05, 64'hC3, 8, 0, 8'h08);
    rd(4'h1, v);
    if (v !== 8'h00) begin $display("FAIL flush_status: got %02h exp 00", v); n_err++; end
    n_cmp++;
    rd(4'h2, v);
    if (v !== 8'h00) begin $display("FAIL flush_data: got %02h exp 00", v); n_err++; end
    n_cmp++;
  endtask

  task automatic test_divider;
    logic [7:0] v;
    int found;
    found = -1;
    ui_in = 8'h01;
    wr(4'h0, 8'h35);
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (uo_out[0] === 1'b1) begin found = i; break; end
    end
    if (found != 29) begin $display("FAIL div_latency: got %0d cycles exp 29", found); n_err++; end
    n_cmp++;
    wr(4'h0, 8'h00);
    rd(4'h2, v);
    if (v !== 8'hFF) begin $display("FAIL div_data: got %02h exp ff", v); n_err++; end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_packing();
    test_debias();
    test_overflow();
    test_health();
    test_back_to_back();
    test_divider();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
